max_finder: RTL
===============

# max_finder

Sequential arg-max stage at the output of the DNN top. It latches the packed output vector of the final fully-connected layer, which holds one signed activation per class. It then scans that vector one element per cycle and reports the index of the largest activation as the detected digit on `out`/`out_valid`. The DNN top forwards these as its own `out`/`out_valid`, which the MNIST benches compare against the expected label.

## Interface
Parameters:
- `NUM_INPUTS`, 10: number of class activations per frame; legal range ≥1.
- `DATA_WIDTH`, 16 (`` `dataWidth ``): width of each activation, signed two's complement.
- `OUT_WIDTH`, 32: width of the index output; must be ≥ clog2(NUM_INPUTS).

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_data_valid`  in  1  frame-valid qualifier for `in_data`.
- `in_data`  in  NUM_INPUTS*DATA_WIDTH  packed activations; element i is `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `in_ready`  out  1  high when a new frame can be accepted.
- `out`  out  OUT_WIDTH  index of the maximum element, zero-extended.
- `out_valid`  out  1  one-cycle pulse when `out` is updated.

## Operation
- There are two states, IDLE and SCAN. `in_ready` = (state == IDLE).
- **IDLE:** a frame is accepted on an edge where `in_data_valid` && `in_ready`. On that edge:
  - The full `in_data` vector is latched into an internal register.
  - `max_val` ← element 0, `max_idx` ← 0, `cnt` ← 1.
  - The state moves to SCAN.
- **SCAN:** each edge compares latched element `cnt` against `max_val`.
  - The comparison is signed and strict (>). On a win, `max_val`/`max_idx` are updated.
  - `cnt` then increments.
- **Completion:** the edge at which `cnt` == NUM_INPUTS is reached, or the edge after acceptance when NUM_INPUTS == 1, does the following:
  - `out` ← final `max_idx`, zero-extended to OUT_WIDTH.
  - `out_valid` ← 1.
  - The state returns to IDLE.
- **Ties:** the lowest index wins.
- **Input stability:** `in_data` may change freely after acceptance, because the scan uses only the latched copy.
- **Busy input:** `in_data_valid` while `in_ready` is low is ignored. It is not queued and is not flagged.
- **Output hold:** `out` holds its value until the next completion. `out_valid` is high for exactly one cycle per accepted frame.
- **Reset:** asserting `reset` (low) at any time, including mid-scan, does the following immediately:
  - state=IDLE, `cnt`=0, `max_idx`=0, `max_val`=0.
  - `out`=0, `out_valid`=0, `in_ready`=1.
  - An aborted frame never produces `out_valid`.

## Timing
- Latency: acceptance at edge E0 → `out`/`out_valid` registered at edge E0+NUM_INPUTS. For the default of 10, that is 10 cycles.
- `in_ready` rises on the same edge as `out_valid`. A frame presented during the `out_valid` cycle is accepted at the next edge.
- Maximum throughput is one frame per NUM_INPUTS+1 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset release is synchronous to `clk` at the system level. The block accepts a frame on the first edge after release if `in_data_valid` is high.

## Configuration
- Macro `MAX_FINDER_SCORE_EN`.
- **Defined:** adds output port `out_score` (DATA_WIDTH, signed).
  - It is registered together with `out` and carries the winning activation `max_val`.
  - Reset value is 0, and it holds between frames.
- **Undefined:** the port and its register are absent. Behaviour and timing of all other ports are unchanged.

## Test plan
All scenarios use NUM_INPUTS=10 and DATA_WIDTH=16.
- **Reset state:** hold `reset`=0 for 5 cycles → `out`=0, `out_valid`=0, `in_ready`=1 (and `out_score`=0 if enabled).
- **Ascending vector:** element i = 3·i → `out`=9 with `out_valid` high exactly one cycle, 10 edges after acceptance; `out_score`=27 if enabled.
- **Signed compare:** element 2=16'h8000, element 7=16'h7FFF, rest 0 → `out`=7. Second frame: all elements 16'hFFFB (−5) except element 4=16'hFFFF (−1) → `out`=4.
- **Tie:** elements 3 and 6 = 100, rest 0 → `out`=3.
- **Busy and back-to-back:**
  - Present frame B (max at index 5) 3 cycles after frame A (max at index 8) was accepted → B is ignored; only `out`=8 is produced.
  - Present B again during A's `out_valid` cycle → B is accepted on the next edge, and `out`=5 follows 11 edges after A's result.
- **Mid-scan reset:** assert `reset` low 5 cycles after acceptance → no `out_valid`, `out`=0. Release reset, then send a frame with max at index 2 → `out`=2 after 10 edges.

Source files
------------

// File: rtl/max_finder.sv
// Sequential arg-max: latches a frame of signed class activations, scans one element per cycle
// and reports the index of the largest. Define MAX_FINDER_SCORE_EN to also export the winning value.
module max_finder #(
  parameter int NUM_INPUTS = 10,
  parameter int DATA_WIDTH = 16,
  parameter int OUT_WIDTH  = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_data_valid,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
  output logic                             in_ready,
  output logic [OUT_WIDTH-1:0]             out,
  output logic                             out_valid
`ifdef MAX_FINDER_SCORE_EN
  ,
  output logic signed [DATA_WIDTH-1:0]     out_score
`endif
);

  // cnt must be able to hold NUM_INPUTS itself, which marks the completion edge
  localparam int CNT_W = $clog2(NUM_INPUTS + 1);
  localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                           state_reg, state_next;
  logic [NUM_INPUTS*DATA_WIDTH-1:0] data_reg;
  logic [CNT_W-1:0]                 cnt_reg;
  logic [IDX_W-1:0]                 max_idx_reg;
  logic signed [DATA_WIDTH-1:0]     max_val_reg;
  logic signed [DATA_WIDTH-1:0]     elem [NUM_INPUTS];
  logic signed [DATA_WIDTH-1:0]     cur_elem;
  logic                             accept;
  logic                             scan_done;
  logic                             cur_wins;

  generate
    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_elem
      assign elem[gi] = data_reg[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  always_comb begin
    cur_elem = elem[0];
    for (int i = 1; i < NUM_INPUTS; i++) begin
      if (cnt_reg == CNT_W'(i)) cur_elem = elem[i];
    end
  end

  assign scan_done = (cnt_reg == CNT_W'(NUM_INPUTS));
  // Strict signed compare keeps the lowest index on ties
  assign cur_wins  = (cur_elem > max_val_reg);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept)    state_next = SCAN;
      SCAN:    if (scan_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_reg == IDLE);
    accept   = in_data_valid && in_ready;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_reg    <= '0;
      cnt_reg     <= '0;
      max_idx_reg <= '0;
      max_val_reg <= '0;
      out         <= '0;
      out_valid   <= 1'b0;
`ifdef MAX_FINDER_SCORE_EN
      out_score   <= '0;
`endif
    end else begin
      out_valid <= 1'b0;
      if (accept) begin
        data_reg    <= in_data;
        max_val_reg <= $signed(in_data[DATA_WIDTH-1:0]);
        max_idx_reg <= '0;
        cnt_reg     <= CNT_W'(1);
      end else if (state_reg == SCAN) begin
        if (scan_done) begin
          out       <= OUT_WIDTH'(max_idx_reg);
          out_valid <= 1'b1;
`ifdef MAX_FINDER_SCORE_EN
          out_score <= max_val_reg;
`endif
        end else begin
          if (cur_wins) begin
            max_val_reg <= cur_elem;
            max_idx_reg <= IDX_W'(cnt_reg);
          end
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end
    end
  end

endmodule
